// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, reset PC default and alignment helpers
package cpu_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    // A PC is legal only when it points at a 32-bit word boundary.
    function automatic logic misaligned(input logic [31:0] addr);
        return |(addr[1:0] & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: program counter register and single-outstanding instruction fetch FSM
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic        pc_wr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid,
    output logic        addr_err,
    output logic [31:0] fetch_cnt
);

    if (misaligned(RESET_PC)) begin : g_bad_reset_pc
        $error("pc_fetch: RESET_PC must be word-aligned");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q;
    logic [31:0]  cnt_q;
    logic         err_q;
    logic         pend_vld_q;
    logic [31:0]  pend_pc_q;
    logic         load_pc, load_instr, set_err, set_pend, clr_pend;
    logic         pend_hit;
    logic [31:0]  pend_tgt, valid_tgt;

    // A redirect seen in the same cycle as the ack counts as already pending,
    // and a fresh redirect always supersedes an older pending target.
    assign pend_hit  = redirect | pend_vld_q;
    assign pend_tgt  = redirect ? redirect_pc : pend_pc_q;
    assign valid_tgt = redirect ? redirect_pc : npc_in;

    // Next-state and control strobes; every output defaulted first.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_pc    = 1'b0;
        load_instr = 1'b0;
        set_err    = 1'b0;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        imem_req   = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack && pend_hit) begin
                    load_pc  = 1'b1;
                    pc_d     = pend_tgt;
                    clr_pend = 1'b1;
                    set_err  = misaligned(pend_tgt);
                    state_d  = misaligned(pend_tgt) ? S_ERR : S_REQ;
                end else if (imem_ack) begin
                    load_instr = 1'b1;
                    state_d    = S_VALID;
                end else begin
                    set_pend = redirect;
                end
            end
            S_VALID: begin
                if (!stall && (redirect || pc_wr)) begin
                    load_pc = 1'b1;
                    pc_d    = valid_tgt;
                    set_err = misaligned(valid_tgt);
                    state_d = misaligned(valid_tgt) ? S_ERR : S_REQ;
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // PC, delivered instruction, counter, sticky trap and pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            if (load_pc) pc_q <= pc_d;
            if (load_instr) begin
                instr_q <= imem_rdata;
                cnt_q   <= cnt_q + 32'd1;
            end
            if (set_err) err_q <= 1'b1;
            if (clr_pend) begin
                pend_vld_q <= 1'b0;
            end else if (set_pend) begin
                pend_vld_q <= 1'b1;
                pend_pc_q  <= redirect_pc;
            end
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr   = pc_q;
    assign instr_o     = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign addr_err    = err_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven directed test of pc_fetch plus reset corner sequences
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc_in, redirect_pc, imem_rdata;
    logic        pc_wr, stall, redirect, imem_ack;
    logic        imem_req, instr_valid, addr_err;
    logic [31:0] imem_addr, pc_o, instr_o, fetch_cnt;

    int total = 0;
    int bad   = 0;

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .pc_wr(pc_wr), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc_o(pc_o), .instr_o(instr_o), .instr_valid(instr_valid),
        .addr_err(addr_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_wr, stall, redirect, ack;
        logic [31:0] npc, rpc, rdata;
        logic        e_req, e_valid, e_err;
        logic [31:0] e_pc, e_instr, e_cnt;
    } vec_t;

    function automatic vec_t mk(logic w, logic s, logic r, logic a,
                                logic [31:0] npc, logic [31:0] rpc, logic [31:0] rd,
                                logic eq, logic ev, logic ee,
                                logic [31:0] ep, logic [31:0] ei, logic [31:0] ec);
        vec_t v;
        v.pc_wr = w; v.stall = s; v.redirect = r; v.ack = a;
        v.npc = npc; v.rpc = rpc; v.rdata = rd;
        v.e_req = eq; v.e_valid = ev; v.e_err = ee;
        v.e_pc = ep; v.e_instr = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eq, input logic ev, input logic ee,
                           input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] ec);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, eq});
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, ee});
        chk({tag, ".pc_o"}, pc_o, ep);
        chk({tag, ".imem_addr"}, imem_addr, ep);
        chk({tag, ".instr_o"}, instr_o, ei);
        chk({tag, ".fetch_cnt"}, fetch_cnt, ec);
    endtask

    task automatic drive(input logic w, input logic s, input logic r, input logic a,
                         input logic [31:0] npc, input logic [31:0] rpc, input logic [31:0] rd);
        pc_wr = w; stall = s; redirect = r; imem_ack = a;
        npc_in = npc; redirect_pc = rpc; imem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[25];

    initial begin
        // inputs: pc_wr stall redirect ack npc rpc rdata | expected: req valid err pc instr cnt
        vecs[0]  = mk(0,0,0,0, 0, 0, 0,                         1,0,0, 32'h3000, 0, 0);
        vecs[1]  = mk(0,0,0,1, 0, 0, 32'h2002_0005,             0,1,0, 32'h3000, 32'h2002_0005, 1);
        vecs[2]  = mk(1,1,0,0, 32'h3004, 0, 0,                  0,1,0, 32'h3000, 32'h2002_0005, 1);
        vecs[3]  = mk(1,1,0,0, 32'h3004, 0, 0,                  0,1,0, 32'h3000, 32'h2002_0005, 1);
        vecs[4]  = mk(1,1,0,0, 32'h3004, 0, 0,                  0,1,0, 32'h3000, 32'h2002_0005, 1);
        vecs[5]  = mk(1,0,0,0, 32'h3004, 0, 0,                  1,0,0, 32'h3004, 32'h2002_0005, 1);
        vecs[6]  = mk(1,0,0,0, 32'h9999, 0, 0,                  1,0,0, 32'h3004, 32'h2002_0005, 1);
        vecs[7]  = mk(1,0,0,0, 32'h9999, 0, 0,                  1,0,0, 32'h3004, 32'h2002_0005, 1);
        vecs[8]  = mk(1,0,0,0, 32'h9999, 0, 0,                  1,0,0, 32'h3004, 32'h2002_0005, 1);
        vecs[9]  = mk(1,0,0,0, 32'h9999, 0, 0,                  1,0,0, 32'h3004, 32'h2002_0005, 1);
        vecs[10] = mk(0,0,0,1, 0, 0, 32'hAAAA_0001,             0,1,0, 32'h3004, 32'hAAAA_0001, 2);
        vecs[11] = mk(0,0,0,0, 32'h5000, 0, 0,                  0,1,0, 32'h3004, 32'hAAAA_0001, 2);
        vecs[12] = mk(1,0,1,0, 32'h3008, 32'h3200, 0,           1,0,0, 32'h3200, 32'hAAAA_0001, 2);
        vecs[13] = mk(0,1,1,0, 0, 32'h3100, 0,                  1,0,0, 32'h3200, 32'hAAAA_0001, 2);
        vecs[14] = mk(0,0,0,0, 0, 32'h7777, 0,                  1,0,0, 32'h3200, 32'hAAAA_0001, 2);
        vecs[15] = mk(0,0,0,1, 0, 0, 32'hDEAD_BEEF,             1,0,0, 32'h3100, 32'hAAAA_0001, 2);
        vecs[16] = mk(0,0,0,1, 0, 0, 32'h1111_2222,             0,1,0, 32'h3100, 32'h1111_2222, 3);
        vecs[17] = mk(0,0,1,0, 0, 32'h3300, 0,                  1,0,0, 32'h3300, 32'h1111_2222, 3);
        vecs[18] = mk(0,0,1,0, 0, 32'h3400, 0,                  1,0,0, 32'h3300, 32'h1111_2222, 3);
        vecs[19] = mk(0,0,1,1, 0, 32'h3500, 32'hBAD0_0001,      1,0,0, 32'h3500, 32'h1111_2222, 3);
        vecs[20] = mk(0,0,1,1, 0, 32'h3600, 32'hBAD0_0002,      1,0,0, 32'h3600, 32'h1111_2222, 3);
        vecs[21] = mk(0,0,0,1, 0, 0, 32'h3333_4444,             0,1,0, 32'h3600, 32'h3333_4444, 4);
        vecs[22] = mk(1,0,0,0, 32'h3006, 0, 0,                  0,0,1, 32'h3006, 32'h3333_4444, 4);
        vecs[23] = mk(1,0,1,1, 32'h3010, 32'h4000, 32'h0BAD_0BAD, 0,0,1, 32'h3006, 32'h3333_4444, 4);
        vecs[24] = mk(0,0,0,1, 0, 0, 32'h0BAD_0BAD,             0,0,1, 32'h3006, 32'h3333_4444, 4);

        rst_n = 1'b0;
        drive(0,0,0,0, 0, 0, 0);
        tick();
        chk_all("reset", 0, 0, 0, 32'h3000, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].pc_wr, vecs[i].stall, vecs[i].redirect, vecs[i].ack,
                  vecs[i].npc, vecs[i].rpc, vecs[i].rdata);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_err,
                    vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_cnt);
        end

        // Only reset leaves the error state, and it acts without a clock edge.
        rst_n = 1'b0;
        #1;
        chk_all("err_reset", 0, 0, 0, 32'h3000, 0, 0);
        rst_n = 1'b1;
        drive(0,0,0,0, 0, 0, 0);
        tick();
        drive(0,0,0,1, 0, 0, 32'hC0DE_0001);
        tick();
        chk_all("refetch", 0, 1, 0, 32'h3000, 32'hC0DE_0001, 1);
        drive(1,0,0,0, 32'h3010, 0, 0);
        tick();
        chk_all("mid_req", 1, 0, 0, 32'h3010, 32'hC0DE_0001, 1);

        // Async reset mid-request, then a late ack while booting is ignored.
        drive(0,0,0,1, 0, 0, 32'h5555_5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 32'h3000, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("late_ack", 1, 0, 0, 32'h3000, 0, 0);
        drive(0,0,0,0, 0, 0, 0);
        tick();
        chk_all("req_hold", 1, 0, 0, 32'h3000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter one per line: name, default, meaning; only RESET_PC exists.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 npc_in  input  32  next-PC value from the next-PC unit (sequential, branch, jump or register target).
REQ-006 pc_wr  input  1  control request to advance PC to npc_in.
REQ-007 stall  input  1  pipeline hold; blocks PC advance.
REQ-008 redirect  input  1  high-priority PC override.
REQ-009 redirect_pc  input  32  override target.
REQ-010 imem_ack  input  1  instruction memory accepts request and returns data this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 imem_req  output  1  fetch request.
REQ-013 imem_addr  output  32  fetch address, equal to pc_o.
REQ-014 pc_o  output  32  current PC, fed back to the next-PC unit.
REQ-015 instr_o  output  32  registered instruction of pc_o.
REQ-016 instr_valid  output  1  instr_o valid for pc_o.
REQ-017 addr_err  output  1  misaligned PC trap flag, sticky.
REQ-018 fetch_cnt  output  32  delivered-instruction counter.

Function
REQ-019 FSM states S_BOOT, S_REQ, S_VALID, S_ERR; reset enters S_BOOT, next edge enters S_REQ unconditionally.
REQ-020 S_REQ: imem_req=1, imem_addr=pc_o held stable until imem_ack; instr_valid=0.
REQ-021 S_REQ with imem_ack=1 and no pending redirect: instr_o<=imem_rdata, instr_valid<=1, fetch_cnt<=fetch_cnt+1 (wraps 2^32-1 to 0), go S_VALID; minimum latency req-to-valid is one edge.
REQ-022 S_VALID: imem_req=0; state held while stall=1 or (pc_wr=0 and redirect=0).
REQ-023 S_VALID, stall=0: target = redirect_pc if redirect=1, else npc_in if pc_wr=1; on edge pc_o<=target, instr_valid<=0.
REQ-024 Target with bits[1:0]!=0: pc_o still updated, addr_err<=1, go S_ERR; else go S_REQ.
REQ-025 redirect asserted in S_REQ (stall ignored): latch redirect_pc into pending register; pc_o and imem_addr unchanged until ack.
REQ-026 On ack with pending redirect: discard imem_rdata, fetch_cnt unchanged, pc_o<=pending target, clear pending, re-enter S_REQ (or S_ERR if misaligned).
REQ-027 Redirect and ack in same S_REQ cycle: treated as pending-then-ack; data discarded, redirect target loaded.
REQ-028 Later redirect in S_REQ overwrites earlier pending target.
REQ-029 pc_wr in S_REQ ignored.
REQ-030 S_ERR: imem_req=0, instr_valid=0, all inputs ignored; exit only via reset.

Reset
REQ-031 rst_n low asynchronously: pc_o=RESET_PC, state S_BOOT, imem_req=0, instr_o=0, instr_valid=0, addr_err=0, fetch_cnt=0, pending cleared.
REQ-032 Reset during outstanding request abandons it; late imem_ack after reset ignored outside S_REQ.
REQ-033 RESET_PC must be word-aligned; misaligned value is a configuration error.

Structure
REQ-034 State encodings, RESET_PC default and alignment-mask constants in shared package cpu_pkg.
REQ-035 Single module; no sub-module; NPC computation remains external.

Verification
REQ-036 Reset release, ack next cycle with 32'h2002_0005 -> imem_addr=32'h0000_3000, instr_valid=1 with instr_o=32'h2002_0005, fetch_cnt=1.
REQ-037 S_VALID, pc_wr=1, stall=1 for 3 cycles, npc_in=32'h0000_3004 -> pc_o stays 32'h0000_3000; stall drop -> pc_o=32'h0000_3004, imem_req=1.
REQ-038 S_REQ, ack delayed 4 cycles -> imem_req and imem_addr stable all 4 cycles; valid one edge after ack.
REQ-039 S_REQ, redirect=1 redirect_pc=32'h0000_3100, ack two cycles later -> data discarded, fetch_cnt unchanged, next imem_addr=32'h0000_3100.
REQ-040 S_VALID, pc_wr=1 npc_in=32'h0000_3006 -> addr_err=1, pc_o=32'h0000_3006, imem_req=0 thereafter until rst_n low.
REQ-041 rst_n low mid-request -> all outputs return to reset values immediately, without clock edge.
